// File: rtl/tone_stream_writer_pkg.sv
// Shared types and default widths for the tone stream writer.
package tone_stream_writer_pkg;

   localparam int DATA_W_DEF    = 24;
   localparam int GAIN_W_DEF    = 8;
   localparam int FADE_STEP_DEF = 16;
   localparam int DUR_W_DEF     = 20;

   typedef enum logic [1:0] {IDLE, FADE_IN, SUSTAIN, FADE_OUT} env_state_t;
   typedef enum logic [1:0] {S_REQ, S_MUL, S_WR} path_state_t;
   typedef logic signed [DATA_W_DEF-1:0] sample_t;

endpackage

// File: rtl/tone_stream_writer_sample_scaler.sv
// Registered signed sample * unsigned gain, scaled back by 2**GAIN_W with floor rounding.
module tone_stream_writer_sample_scaler #(
   parameter int DATA_W = 24,
   parameter int GAIN_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] sample,
   input  logic        [GAIN_W:0]   gain,
   output logic signed [DATA_W-1:0] scaled
);

   localparam int PROD_W = DATA_W + GAIN_W + 1;

   logic signed [PROD_W-1:0] sample_ext;
   logic signed [PROD_W-1:0] gain_ext;
   logic signed [PROD_W-1:0] product;

   assign sample_ext = PROD_W'(sample);
   assign gain_ext   = PROD_W'($signed({1'b0, gain}));
   assign product    = sample_ext * gain_ext;

   // Arithmetic shift floors negative results; unity gain is exact.
   always_ff @(posedge clk) begin
      if (reset) begin
         scaled <= '0;
      end else if (en) begin
         scaled <= DATA_W'(product >>> GAIN_W);
      end
   end

endmodule

// File: rtl/tone_stream_writer.sv
// Pulls generator samples, applies a linear fade envelope and optional duration,
// and writes each scaled sample to both codec channels.
//
// state     | meaning
// IDLE      | silent, gain 0, waiting for play
// FADE_IN   | gain rises by FADE_STEP per written sample
// SUSTAIN   | unity gain
// FADE_OUT  | gain falls by FADE_STEP; the gain-0 write returns to IDLE
// S_REQ     | capture sample and gain, advance generator
// S_MUL     | multiply
// S_WR      | hold write until the codec accepts it
module tone_stream_writer
   import tone_stream_writer_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int GAIN_W    = GAIN_W_DEF,
   parameter int FADE_STEP = FADE_STEP_DEF,
   parameter int DUR_W     = DUR_W_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     play,
   input  logic        [DUR_W-1:0]  duration,
   input  logic signed [DATA_W-1:0] sample_in,
   output logic                     sample_en,
   input  logic                     write_ready,
   output logic                     write,
   output logic signed [DATA_W-1:0] writedata_left,
   output logic signed [DATA_W-1:0] writedata_right,
   output logic                     busy,
   output logic                     done
);

   localparam logic [GAIN_W:0] UNITY = (GAIN_W+1)'(2**GAIN_W);
   localparam logic [GAIN_W:0] STEP  = (GAIN_W+1)'(FADE_STEP);

   env_state_t               env;
   path_state_t              path;
   logic [GAIN_W:0]          gain;
   logic [GAIN_W:0]          gain_cap;
   logic [DUR_W-1:0]         count;
   logic [DUR_W-1:0]         dur_q;
   logic signed [DATA_W-1:0] sample_q;
   logic signed [DATA_W-1:0] scaled;
   logic [GAIN_W+1:0]        gain_inc;
   logic [GAIN_W:0]          gain_dec;
   logic [DUR_W:0]           count_inc;
   logic                     release_now;

   assign gain_inc    = {1'b0, gain} + {1'b0, STEP};
   assign gain_dec    = (gain > STEP) ? gain - STEP : '0;
   assign count_inc   = {1'b0, count} + (DUR_W+1)'(1);
   // count_inc is one bit wider so a saturated count still ends a timed tone.
   assign release_now = !play || ((dur_q != '0) && (count_inc >= {1'b0, dur_q}));

   always_ff @(posedge clk) begin
      if (reset) begin
         env       <= IDLE;
         path      <= S_REQ;
         gain      <= '0;
         gain_cap  <= '0;
         count     <= '0;
         dur_q     <= '0;
         sample_q  <= '0;
         sample_en <= 1'b0;
         write     <= 1'b0;
         done      <= 1'b0;
      end else begin
         sample_en <= 1'b0;
         done      <= 1'b0;
         if (env == IDLE) begin
            path <= S_REQ;
            if (play) begin
               env   <= FADE_IN;
               dur_q <= duration;
               gain  <= '0;
               count <= '0;
            end
         end else begin
            case (path)
               S_REQ: begin
                  sample_q  <= sample_in;
                  gain_cap  <= gain;
                  sample_en <= 1'b1;
                  path      <= S_MUL;
               end
               S_MUL: begin
                  write <= 1'b1;
                  path  <= S_WR;
               end
               S_WR: begin
                  if (write_ready) begin
                     write <= 1'b0;
                     path  <= S_REQ;
                     if (count != '1) count <= count + DUR_W'(1);
                     if (env == FADE_OUT) begin
                        if (gain == '0) begin
                           env   <= IDLE;
                           done  <= 1'b1;
                           count <= '0;
                        end else begin
                           gain <= gain_dec;
                        end
                     end else if (release_now) begin
                        env  <= FADE_OUT;
                        gain <= gain_dec;
                     end else if (gain_inc >= {1'b0, UNITY}) begin
                        env  <= SUSTAIN;
                        gain <= UNITY;
                     end else begin
                        gain <= gain_inc[GAIN_W:0];
                     end
                  end
               end
               default: path <= S_REQ;
            endcase
         end
      end
   end

   tone_stream_writer_sample_scaler #(
      .DATA_W (DATA_W),
      .GAIN_W (GAIN_W)
   ) u_scaler (
      .clk    (clk),
      .reset  (reset),
      .en     (path == S_MUL),
      .sample (sample_q),
      .gain   (gain_cap),
      .scaled (scaled)
   );

   assign writedata_left  = scaled;
   assign writedata_right = scaled;
   assign busy            = (env != IDLE);

endmodule

// File: tb/tb_tone_stream_writer.sv
// Directed bench for tone_stream_writer with GAIN_W=8, FADE_STEP=64.
module tb_tone_stream_writer;

   localparam int DATA_W    = 24;
   localparam int GAIN_W    = 8;
   localparam int FADE_STEP = 64;
   localparam int DUR_W     = 20;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     play;
   logic [DUR_W-1:0]         duration;
   logic signed [DATA_W-1:0] sample_in;
   logic                     sample_en;
   logic                     write_ready;
   logic                     write;
   logic signed [DATA_W-1:0] writedata_left;
   logic signed [DATA_W-1:0] writedata_right;
   logic                     busy;
   logic                     done;

   int checks   = 0;
   int failures = 0;
   int sen_cnt  = 0;
   int wr_cnt   = 0;
   int done_cnt = 0;

   always #10 clk = ~clk;

   tone_stream_writer #(
      .DATA_W    (DATA_W),
      .GAIN_W    (GAIN_W),
      .FADE_STEP (FADE_STEP),
      .DUR_W     (DUR_W)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .play            (play),
      .duration        (duration),
      .sample_in       (sample_in),
      .sample_en       (sample_en),
      .write_ready     (write_ready),
      .write           (write),
      .writedata_left  (writedata_left),
      .writedata_right (writedata_right),
      .busy            (busy),
      .done            (done)
   );

   always @(negedge clk) begin
      if (sample_en) sen_cnt++;
      if (write && write_ready) wr_cnt++;
      if (done) done_cnt++;
   end

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Returns at the negedge before an accepting posedge.
   task automatic wait_wr(output logic signed [DATA_W-1:0] l, output logic signed [DATA_W-1:0] r,
                          output bit ok);
      ok = 1'b0;
      l  = '0;
      r  = '0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (write && write_ready) begin
            l  = writedata_left;
            r  = writedata_right;
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; play = 1'b0; duration = '0; sample_in = 200000; write_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (write !== 1'b0) begin failures++; $display("FAIL reset_write: got %0b want 0", write); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b want 0", done); end
      checks++; if (sample_en !== 1'b0) begin failures++; $display("FAIL reset_sample_en: got %0b want 0", sample_en); end
      checks++; if (writedata_left !== 0) begin failures++; $display("FAIL reset_wd_left: got %0d want 0", writedata_left); end
      checks++; if (writedata_right !== 0) begin failures++; $display("FAIL reset_wd_right: got %0d want 0", writedata_right); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %0b want 0", busy); end
   endtask

   task automatic test_fade_in;
      int exp_v [11] = '{0, 50000, 100000, 150000, 200000, 200000, 200000, 150000, 100000, 50000, 0};
      logic signed [DATA_W-1:0] l, r;
      bit ok;
      longint t_prev;
      int s0, w0, d0;
      settle(1);
      s0 = sen_cnt; w0 = wr_cnt; d0 = done_cnt; t_prev = 0;
      sample_in = 200000; duration = '0; play = 1'b1;
      for (int i = 0; i < 11; i++) begin
         wait_wr(l, r, ok);
         checks++;
         if (!ok) begin
            failures++; $display("FAIL fade_in_timeout: write %0d never arrived", i);
         end else begin
            if (l !== exp_v[i]) begin failures++; $display("FAIL fade_in_data[%0d]: got %0d want %0d", i, l, exp_v[i]); end
            checks++;
            if (r !== l) begin failures++; $display("FAIL fade_in_lr[%0d]: right %0d left %0d", i, r, l); end
            if (i > 0) begin
               checks++;
               if ($time - t_prev != 60) begin failures++; $display("FAIL fade_in_spacing[%0d]: got %0d ns want 60", i, $time - t_prev); end
            end
            t_prev = $time;
         end
         if (i == 6) play = 1'b0;
      end
      wait_done(ok);
      checks++; if (!ok) begin failures++; $display("FAIL fade_in_done: timeout"); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fade_in_busy_at_done: got %0b want 0", busy); end
      settle(3);
      checks++; if (sen_cnt - s0 != 11) begin failures++; $display("FAIL fade_in_sample_en: got %0d want 11", sen_cnt - s0); end
      checks++; if (wr_cnt - w0 != 11) begin failures++; $display("FAIL fade_in_writes: got %0d want 11", wr_cnt - w0); end
      checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL fade_in_done_count: got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_floor;
      int exp_v [5] = '{0, -50001, -100001, -50001, 0};
      logic signed [DATA_W-1:0] l, r;
      bit ok;
      sample_in = -200001; duration = '0; play = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_wr(l, r, ok);
         checks++;
         if (!ok) begin
            failures++; $display("FAIL floor_timeout: write %0d never arrived", i);
         end else begin
            if (l !== exp_v[i]) begin failures++; $display("FAIL floor_data[%0d]: got %0d want %0d", i, l, exp_v[i]); end
            checks++;
            if (r !== l) begin failures++; $display("FAIL floor_lr[%0d]: right %0d left %0d", i, r, l); end
         end
         if (i == 2) play = 1'b0;
      end
      wait_done(ok);
      checks++; if (!ok) begin failures++; $display("FAIL floor_done: timeout"); end
   endtask

   task automatic test_duration;
      int exp_v [12] = '{0, 50000, 100000, 150000, 200000, 200000, 200000, 200000,
                         150000, 100000, 50000, 0};
      logic signed [DATA_W-1:0] l, r;
      bit ok;
      int d0;
      settle(1);
      d0 = done_cnt;
      sample_in = 200000; duration = 8; play = 1'b1;
      for (int i = 0; i < 12; i++) begin
         wait_wr(l, r, ok);
         checks++;
         if (!ok) begin
            failures++; $display("FAIL duration_timeout: write %0d never arrived", i);
         end else if (l !== exp_v[i]) begin
            failures++; $display("FAIL duration_data[%0d]: got %0d want %0d", i, l, exp_v[i]);
         end
         if (i == 0) duration = '0;
      end
      wait_done(ok);
      play = 1'b0;
      checks++; if (!ok) begin failures++; $display("FAIL duration_done: timeout"); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL duration_busy_at_done: got %0b want 0", busy); end
      settle(4);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL duration_busy_after: got %0b want 0", busy); end
      checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL duration_done_count: got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_release_retrigger;
      int exp_v [7] = '{0, 50000, 100000, 50000, 0, 0, 50000};
      logic signed [DATA_W-1:0] l, r;
      bit ok;
      longint t_prev;
      int d0;
      settle(1);
      d0 = done_cnt; t_prev = 0;
      sample_in = 200000; duration = '0; play = 1'b1;
      for (int i = 0; i < 7; i++) begin
         wait_wr(l, r, ok);
         checks++;
         if (!ok) begin
            failures++; $display("FAIL retrig_timeout: write %0d never arrived", i);
         end else begin
            if (l !== exp_v[i]) begin failures++; $display("FAIL retrig_data[%0d]: got %0d want %0d", i, l, exp_v[i]); end
            if (i == 5) begin
               checks++;
               if ($time - t_prev != 80) begin failures++; $display("FAIL retrig_gap: got %0d ns want 80", $time - t_prev); end
            end
            t_prev = $time;
         end
         if (i == 2) play = 1'b0;
         if (i == 3) play = 1'b1;
         if (i == 6) play = 1'b0;
      end
      wait_done(ok);
      checks++; if (!ok) begin failures++; $display("FAIL retrig_done: timeout"); end
      settle(2);
      checks++; if (done_cnt - d0 != 2) begin failures++; $display("FAIL retrig_done_count: got %0d want 2", done_cnt - d0); end
   endtask

   task automatic test_stall;
      logic signed [DATA_W-1:0] l, r;
      bit ok;
      int s0;
      sample_in = 200000; duration = '0; play = 1'b1; write_ready = 1'b1;
      wait_wr(l, r, ok);
      checks++; if (!ok) begin failures++; $display("FAIL stall_first: timeout"); end
      @(posedge clk);
      #1;
      write_ready = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (write) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin failures++; $display("FAIL stall_write_rise: timeout"); end
      #1;
      s0 = sen_cnt;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checks++; if (write !== 1'b1) begin failures++; $display("FAIL stall_write_held[%0d]: got %0b want 1", k, write); end
         checks++; if (writedata_left !== 50000) begin failures++; $display("FAIL stall_data[%0d]: got %0d want 50000", k, writedata_left); end
      end
      #1;
      checks++; if (sen_cnt != s0) begin failures++; $display("FAIL stall_sample_en: got %0d extra want 0", sen_cnt - s0); end
      write_ready = 1'b1;
      @(negedge clk);
      checks++; if (write !== 1'b0) begin failures++; $display("FAIL stall_single_write: got %0b want 0", write); end
      wait_wr(l, r, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL stall_next: timeout"); end
      else if (l !== 100000) begin failures++; $display("FAIL stall_next_data: got %0d want 100000", l); end
      play = 1'b0;
      wait_done(ok);
      checks++; if (!ok) begin failures++; $display("FAIL stall_done: timeout"); end
   endtask

   task automatic test_reset_mid;
      int exp_v [6] = '{0, 50000, 100000, 150000, 200000, 200000};
      logic signed [DATA_W-1:0] l, r;
      bit ok;
      int d0;
      settle(1);
      d0 = done_cnt;
      sample_in = 200000; duration = '0; play = 1'b1; write_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wait_wr(l, r, ok);
         checks++;
         if (!ok) begin failures++; $display("FAIL rmid_timeout: write %0d never arrived", i); end
         else if (l !== exp_v[i]) begin failures++; $display("FAIL rmid_data[%0d]: got %0d want %0d", i, l, exp_v[i]); end
      end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (write !== 1'b0) begin failures++; $display("FAIL rmid_write: got %0b want 0", write); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %0b want 0", busy); end
      checks++; if (writedata_left !== 0) begin failures++; $display("FAIL rmid_data_clear: got %0d want 0", writedata_left); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL rmid_done: got %0b want 0", done); end
      @(negedge clk);
      reset = 1'b0;
      wait_wr(l, r, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rmid_replay0: timeout"); end
      else if (l !== 0) begin failures++; $display("FAIL rmid_replay0_data: got %0d want 0", l); end
      wait_wr(l, r, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rmid_replay1: timeout"); end
      else if (l !== 50000) begin failures++; $display("FAIL rmid_replay1_data: got %0d want 50000", l); end
      play = 1'b0;
      wait_done(ok);
      checks++; if (!ok) begin failures++; $display("FAIL rmid_done_final: timeout"); end
      settle(2);
      checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL rmid_done_count: got %0d want 1", done_cnt - d0); end
   endtask

   initial begin
      test_reset();
      test_fade_in();
      test_floor();
      test_duration();
      test_release_retrigger();
      test_stall();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
